// File: rtl/cdc_handshake_rx.sv
// Destination-side receiver of a four-phase req/ack handshake.
// Synchronizes req into Bclk, captures Din once the request is seen, and returns a registered level ack.
module cdc_handshake_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Bclk,
  input  logic       reset,
  input  logic       req,
  input  logic [3:0] Din,
  output logic       ack,
  output logic [3:0] Dout,
  output logic       valid,
  output logic [7:0] count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [3:0]             dout_q, dout_d;
  logic [7:0]             count_q, count_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Only the last synchronizer stage is allowed to reach the FSM.
  assign req_s  = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], req};

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = 1'b0;
    dout_d  = dout_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (req_s) begin
          state_d = CAPTURE;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        // Din is stable here: the sender holds it until it sees ack.
        state_d = ACK;
        dout_d  = Din;
        valid_d = 1'b1;
        ack_d   = 1'b1;
        count_d = sat_inc(count_q);
      end
      ACK: begin
        if (req_s) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, synchronizer and output registers.
  always_ff @(posedge Bclk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= 4'b0000;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      count_q <= count_d;
    end
  end

  assign ack   = ack_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign Dout  = dout_q;
  assign count = count_q;

endmodule
